// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared constants and the state type for the router write-side controller.
//   NUM_PORTS     number of output FIFOs (valid addresses 0..NUM_PORTS-1)
//   ADDR_W        width of the header address field
//   INVALID_ADDR  the one address encoding that selects no FIFO
//   router_state_e  sequencing states of router_fsm_ctrl
// -----------------------------------------------------------------------------
package router_pkg;

    localparam int          NUM_PORTS    = 3;
    localparam int          ADDR_W       = 2;
    localparam logic [1:0]  INVALID_ADDR = 2'b11;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        WAIT_TILL_EMPTY    = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        LOAD_PARITY        = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } router_state_e;

endpackage

// File: rtl/router_fsm_ctrl.sv
// -----------------------------------------------------------------------------
// router_fsm_ctrl
// Packet-sequencing controller for the 1x3 router write side. Decodes the
// header address, waits for the target FIFO to drain, then sequences the
// header, payload and parity loads. Returns to DECODE_ADDRESS when the packet
// completes or when the selected port is soft-reset.
//
// Ports
//   clock          in   single clock, posedge
//   resetn         in   synchronous active-low reset
//   pkt_valid      in   source packet valid
//   data_in        in   header address bits (sampled in DECODE_ADDRESS)
//   fifo_full      in   selected FIFO full
//   fifo_empty     in   per-FIFO empty flags
//   soft_reset     in   per-FIFO soft reset (only the selected port matters)
//   parity_done    in   parity byte captured by the register block
//   low_pkt_valid  in   pkt_valid fell while the FIFO was full
//   addr_o         out  latched destination address
//   detect_add .. full_state   out  one-hot state flags
//   write_enb_reg  out  FIFO write strobe
//   rst_int_reg    out  clear internal parity registers
//   busy           out  source must hold data_in
// -----------------------------------------------------------------------------
module router_fsm_ctrl
    import router_pkg::*;
(
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  pkt_valid,
    input  logic [ADDR_W-1:0]     data_in,
    input  logic                  fifo_full,
    input  logic [NUM_PORTS-1:0]  fifo_empty,
    input  logic [NUM_PORTS-1:0]  soft_reset,
    input  logic                  parity_done,
    input  logic                  low_pkt_valid,
    output logic [ADDR_W-1:0]     addr_o,
    output logic                  detect_add,
    output logic                  lfd_state,
    output logic                  ld_state,
    output logic                  laf_state,
    output logic                  full_state,
    output logic                  write_enb_reg,
    output logic                  rst_int_reg,
    output logic                  busy
);

    localparam logic [ADDR_W:0] NP = NUM_PORTS[ADDR_W:0];

    router_state_e      r_state;
    router_state_e      w_next;
    logic [ADDR_W-1:0]  r_addr;
    logic               w_latch;
    logic               w_addr_ok;
    logic               w_dec_empty;
    logic               w_sel_empty;
    logic               w_sel_srst;

    // Guard the variable indexes: data_in can carry the invalid encoding.
    assign w_addr_ok   = ({1'b0, data_in} < NP);
    assign w_dec_empty = w_addr_ok && fifo_empty[data_in];
    // r_addr only ever latches a valid address, the guard is belt-and-braces.
    assign w_sel_empty = ({1'b0, r_addr} < NP) && fifo_empty[r_addr];
    assign w_sel_srst  = ({1'b0, r_addr} < NP) && soft_reset[r_addr];

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= DECODE_ADDRESS;
            r_addr  <= '0;
        end else begin
            r_state <= w_next;
            if (w_latch) r_addr <= data_in;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_latch = 1'b0;
        if (w_sel_srst) begin
            // Soft reset of the selected port aborts the packet; no latch.
            w_next = DECODE_ADDRESS;
        end else begin
            case (r_state)
                DECODE_ADDRESS: begin
                    if (pkt_valid && w_addr_ok) begin
                        w_latch = 1'b1;
                        w_next  = w_dec_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end
                end
                WAIT_TILL_EMPTY:
                    if (w_sel_empty) w_next = LOAD_FIRST_DATA;
                LOAD_FIRST_DATA:
                    w_next = LOAD_DATA;
                LOAD_DATA: begin
                    // Full takes precedence over end-of-packet.
                    if (fifo_full)       w_next = FIFO_FULL_STATE;
                    else if (!pkt_valid) w_next = LOAD_PARITY;
                end
                FIFO_FULL_STATE:
                    if (!fifo_full) w_next = LOAD_AFTER_FULL;
                LOAD_AFTER_FULL: begin
                    if (parity_done)        w_next = DECODE_ADDRESS;
                    else if (low_pkt_valid) w_next = LOAD_PARITY;
                    else                    w_next = LOAD_DATA;
                end
                LOAD_PARITY:
                    w_next = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR:
                    w_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                default:
                    w_next = DECODE_ADDRESS;
            endcase
        end
    end

    // Moore outputs straight from the state register.
    assign addr_o        = r_addr;
    assign detect_add    = (r_state == DECODE_ADDRESS);
    assign lfd_state     = (r_state == LOAD_FIRST_DATA);
    assign ld_state      = (r_state == LOAD_DATA);
    assign laf_state     = (r_state == LOAD_AFTER_FULL);
    assign full_state    = (r_state == FIFO_FULL_STATE);
    assign write_enb_reg = (r_state == LOAD_DATA) || (r_state == LOAD_PARITY) ||
                           (r_state == LOAD_AFTER_FULL);
    assign rst_int_reg   = (r_state == CHECK_PARITY_ERROR);
    assign busy          = (r_state != DECODE_ADDRESS) && (r_state != LOAD_DATA);

endmodule

// File: tb/tb_router_fsm_ctrl.sv
// -----------------------------------------------------------------------------
// tb_router_fsm_ctrl
// Table-driven header/payload/parity walk, hand sequences for wait, full,
// invalid-address and soft-reset corners, then random traffic against a
// behavioural reference model.
// Output flags are compared as {detect,lfd,ld,laf,full,wen,rst_int,busy}.
// -----------------------------------------------------------------------------
module tb_router_fsm_ctrl;

    logic       clock = 1'b0;
    logic       resetn, pkt_valid, fifo_full, parity_done, low_pkt_valid;
    logic [1:0] data_in;
    logic [2:0] fifo_empty, soft_reset;
    logic [1:0] addr_o;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       write_enb_reg, rst_int_reg, busy;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clock = ~clock;

    router_fsm_ctrl dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .addr_o(addr_o),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
        .rst_int_reg(rst_int_reg), .busy(busy)
    );

    // Expected flag patterns {detect,lfd,ld,laf,full,wen,rst_int,busy}
    localparam logic [7:0] F_DA  = 8'b1000_0000;
    localparam logic [7:0] F_LFD = 8'b0100_0001;
    localparam logic [7:0] F_LD  = 8'b0010_0100;
    localparam logic [7:0] F_LAF = 8'b0001_0101;
    localparam logic [7:0] F_FUL = 8'b0000_1001;
    localparam logic [7:0] F_LP  = 8'b0000_0101;
    localparam logic [7:0] F_CPE = 8'b0000_0011;
    localparam logic [7:0] F_WTE = 8'b0000_0001;

    function automatic logic [7:0] dut_flags();
        return {detect_add, lfd_state, ld_state, laf_state, full_state,
                write_enb_reg, rst_int_reg, busy};
    endfunction

    task automatic chk(input string name, input logic [1:0] ea, input logic [7:0] ef);
        n_chk++;
        if (addr_o === ea && dut_flags() === ef) n_pass++;
        else $display("FAIL %s: got addr=%0d flags=%b, want addr=%0d flags=%b",
                      name, addr_o, dut_flags(), ea, ef);
    endtask

    task automatic drive(input logic pv, input logic [1:0] d, input logic ff,
                         input logic [2:0] fe, input logic [2:0] sr,
                         input logic pd, input logic lpv);
        pkt_valid = pv; data_in = d; fifo_full = ff; fifo_empty = fe;
        soft_reset = sr; parity_done = pd; low_pkt_valid = lpv;
    endtask

    // Clock one edge, then settle before sampling.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        drive(0, 0, 0, 3'b111, 0, 0, 0);
        tick(); tick();
        resetn = 1'b1;
    endtask

    typedef struct {
        logic       pv;
        logic [1:0] d;
        logic       ff;
        logic [2:0] fe;
        logic [2:0] sr;
        logic       pd;
        logic       lpv;
        logic [1:0] ea;
        logic [7:0] ef;
    } vec_t;

    // ---------------- reference model ----------------
    // Named states; next state follows the packet-sequencing rules directly.
    typedef enum int {M_DA, M_LFD, M_LD, M_WTE, M_FUL, M_LAF, M_LP, M_CPE} mst_t;
    mst_t       m_st;
    logic [1:0] m_addr;

    function automatic logic [7:0] m_flags(input mst_t s);
        case (s)
            M_DA:  return F_DA;
            M_LFD: return F_LFD;
            M_LD:  return F_LD;
            M_WTE: return F_WTE;
            M_FUL: return F_FUL;
            M_LAF: return F_LAF;
            M_LP:  return F_LP;
            default: return F_CPE;
        endcase
    endfunction

    task automatic m_step();
        int a;
        if (!resetn) begin
            m_st = M_DA; m_addr = 0; return;
        end
        if (soft_reset[m_addr]) begin
            m_st = M_DA; return;
        end
        case (m_st)
            M_DA: begin
                a = data_in;
                if (pkt_valid && a < 3) begin
                    m_addr = data_in;
                    m_st = fifo_empty[a] ? M_LFD : M_WTE;
                end
            end
            M_WTE: if (fifo_empty[m_addr]) m_st = M_LFD;
            M_LFD: m_st = M_LD;
            M_LD:  if (fifo_full) m_st = M_FUL; else if (!pkt_valid) m_st = M_LP;
            M_FUL: if (!fifo_full) m_st = M_LAF;
            M_LAF: m_st = parity_done ? M_DA : (low_pkt_valid ? M_LP : M_LD);
            M_LP:  m_st = M_CPE;
            M_CPE: m_st = fifo_full ? M_FUL : M_DA;
            default: m_st = M_DA;
        endcase
    endtask

    initial begin
        vec_t tbl[9];

        resetn = 1'b0;
        drive(0, 0, 0, 3'b111, 0, 0, 0);

        // Reset state.
        do_reset();
        chk("reset", 2'd0, F_DA);

        // Full packet to port 1: header, 4 payload, parity, check, idle.
        tbl[0] = '{1, 2'd1, 0, 3'b111, 0, 0, 0, 2'd1, F_LFD};
        tbl[1] = '{1, 2'd0, 0, 3'b111, 0, 0, 0, 2'd1, F_LD};
        tbl[2] = '{1, 2'd2, 0, 3'b111, 0, 0, 0, 2'd1, F_LD};
        tbl[3] = '{1, 2'd3, 0, 3'b111, 0, 0, 0, 2'd1, F_LD};
        tbl[4] = '{1, 2'd0, 0, 3'b111, 0, 0, 0, 2'd1, F_LD};
        tbl[5] = '{0, 2'd0, 0, 3'b111, 0, 0, 0, 2'd1, F_LP};
        tbl[6] = '{0, 2'd0, 0, 3'b111, 0, 0, 0, 2'd1, F_CPE};
        tbl[7] = '{0, 2'd0, 0, 3'b111, 0, 0, 0, 2'd1, F_DA};
        tbl[8] = '{0, 2'd0, 0, 3'b111, 0, 0, 0, 2'd1, F_DA};
        foreach (tbl[i]) begin
            drive(tbl[i].pv, tbl[i].d, tbl[i].ff, tbl[i].fe, tbl[i].sr,
                  tbl[i].pd, tbl[i].lpv);
            tick();
            chk($sformatf("pkt_row%0d", i), tbl[i].ea, tbl[i].ef);
        end

        // Wait for port 2 to drain: four busy cycles, then header.
        do_reset();
        drive(1, 2'd2, 0, 3'b011, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("wait%0d", i), 2'd2, F_WTE);
        end
        fifo_empty = 3'b111;
        tick();
        chk("wait_exit", 2'd2, F_LFD);

        // FIFO full during payload, three full cycles, then load-after-full.
        do_reset();
        drive(1, 2'd0, 0, 3'b111, 0, 0, 0);
        tick(); tick();
        chk("full_pre", 2'd0, F_LD);
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("full%0d", i), 2'd0, F_FUL);
        end
        fifo_full = 1'b0;
        tick();
        chk("laf", 2'd0, F_LAF);
        tick();
        chk("laf_back", 2'd0, F_LD);

        // Full and end-of-packet together: full wins.
        drive(0, 2'd0, 1, 3'b111, 0, 0, 0);
        tick();
        chk("full_prio", 2'd0, F_FUL);

        // Invalid address never leaves decode.
        do_reset();
        drive(1, 2'd3, 0, 3'b111, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("bad_addr%0d", i), 2'd0, F_DA);
        end

        // Soft reset: only the selected port aborts the packet.
        do_reset();
        drive(1, 2'd0, 0, 3'b111, 0, 0, 0);
        tick(); tick();
        soft_reset = 3'b010;
        tick();
        chk("srst_other", 2'd0, F_LD);
        soft_reset = 3'b001;
        tick();
        chk("srst_sel", 2'd0, F_DA);
        soft_reset = 3'b000;

        // Reset mid-packet wins.
        drive(1, 2'd1, 0, 3'b111, 0, 0, 0);
        tick(); tick();
        resetn = 1'b0;
        tick();
        chk("reset_mid", 2'd0, F_DA);
        resetn = 1'b1;

        // Random traffic against the model.
        do_reset();
        m_st = M_DA; m_addr = 0;
        for (int i = 0; i < 3000; i++) begin
            resetn        = ($urandom_range(0, 99) != 0);
            pkt_valid     = ($urandom_range(0, 3) != 0);
            data_in       = 2'($urandom_range(0, 3));
            fifo_full     = ($urandom_range(0, 3) == 0);
            fifo_empty    = 3'($urandom);
            soft_reset    = ($urandom_range(0, 19) == 0) ? 3'($urandom) : 3'b000;
            parity_done   = ($urandom_range(0, 3) == 0);
            low_pkt_valid = ($urandom_range(0, 2) == 0);
            m_step();
            tick();
            chk($sformatf("rand%0d", i), m_addr, m_flags(m_st));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
